// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered opcode decoder acting as the ID/EX pipeline register.
// Decodes op_code into a control word and holds it behind a valid/ready handshake.
// Load/store ops are held back for MEM_WAIT extra cycles before being presented.
// Flush discards whatever the stage is holding and blocks same-cycle input.
module ctrl_decode_stage #(
  parameter int OPCODE_W  = 6,
  parameter int ALU_CMD_W = 4,
  parameter int MEM_WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  op_code,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           branch_type,
  output logic                 wb_enable,
  output logic                 is_immediate,
  output logic                 illegal_op
);

  // Wait counter holds MEM_WAIT-1 down to 0; keep at least one bit when MEM_WAIT is 0.
  localparam int CNT_W  = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  // Control word layout: {alu_cmd, mem_read, mem_write, branch_type[1:0], wb, imm, illegal}
  localparam int WORD_W = ALU_CMD_W + 7;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   pend_q, pend_d;   // word parked during the memory wait
  logic [WORD_W-1:0]   out_q, out_d;     // word presented to execute

  // Opcode split into the table index and the must-be-zero upper bits.
  logic [OPCODE_W+5:0] op_ext;
  logic [5:0]          op_lo;
  logic                op_hi_nz;

  logic [3:0]          dec_alu;
  logic                dec_mr, dec_mw, dec_wb, dec_imm, dec_ill;
  logic [1:0]          dec_br;
  logic                dec_is_mem;
  logic [WORD_W-1:0]   dec_word;

  logic                accept;

  assign op_ext   = {6'd0, op_code};
  assign op_lo    = op_ext[5:0];
  assign op_hi_nz = |(op_ext >> 6);

  // Decode table; anything outside it is flagged illegal with all controls low.
  always_comb begin
    dec_alu = 4'd0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 2'b00;
    dec_wb  = 1'b0;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    if (op_hi_nz) begin
      dec_ill = 1'b1;
    end else begin
      case (op_lo)
        6'd0:        ;
        6'd1:        dec_wb = 1'b1;
        6'd3:        begin dec_alu = 4'b0010; dec_wb = 1'b1; end
        6'd5, 6'd6:  begin dec_alu = 4'b0100; dec_wb = 1'b1; end
        6'd7:        begin dec_alu = 4'b0110; dec_wb = 1'b1; end
        6'd8:        begin dec_alu = 4'b0111; dec_wb = 1'b1; end
        6'd9, 6'd10: begin dec_alu = 4'b1000; dec_wb = 1'b1; end
        6'd11:       begin dec_alu = 4'b1001; dec_wb = 1'b1; end
        6'd12:       begin dec_alu = 4'b1010; dec_wb = 1'b1; end
        6'd32:       begin dec_wb = 1'b1; dec_imm = 1'b1; end
        6'd33:       begin dec_alu = 4'b0010; dec_wb = 1'b1; dec_imm = 1'b1; end
        6'd36:       begin dec_mr = 1'b1; dec_wb = 1'b1; end
        6'd37:       dec_mw = 1'b1;
        6'd40:       dec_br = 2'b01;
        6'd41:       dec_br = 2'b10;
        6'd42:       dec_br = 2'b11;
        default:     dec_ill = 1'b1;
      endcase
    end
  end

  assign dec_is_mem = dec_mr | dec_mw;
  assign dec_word   = {ALU_CMD_W'(dec_alu), dec_mr, dec_mw, dec_br, dec_wb, dec_imm, dec_ill};

  // Handshake: only an empty stage or a draining valid stage takes a new op.
  assign in_ready = rst_n & ~flush &
                    ((state_q == S_EMPTY) | ((state_q == S_VALID) & out_ready));
  assign accept   = in_valid & in_ready;

  // Next-state logic; flush wins over everything, including WAIT expiry.
  always_comb begin
    logic [1:0]        ld_state;
    logic [CNT_W-1:0]  ld_cnt;
    logic [WORD_W-1:0] ld_pend;
    logic [WORD_W-1:0] ld_out;

    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    out_d   = out_q;

    // What loading the current opcode would do, shared by EMPTY and VALID.
    if ((MEM_WAIT > 0) && dec_is_mem) begin
      ld_state = S_WAIT;
      ld_cnt   = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
      ld_pend  = dec_word;
      ld_out   = '0;
    end else begin
      ld_state = S_VALID;
      ld_cnt   = '0;
      ld_pend  = pend_q;
      ld_out   = dec_word;
    end

    if (flush) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
      pend_d  = '0;
      out_d   = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = ld_state;
            cnt_d   = ld_cnt;
            pend_d  = ld_pend;
            out_d   = ld_out;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_VALID;
            out_d   = pend_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            if (accept) begin
              state_d = ld_state;
              cnt_d   = ld_cnt;
              pend_d  = ld_pend;
              out_d   = ld_out;
            end else begin
              state_d = S_EMPTY;
              out_d   = '0;
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
          cnt_d   = '0;
          out_d   = '0;
        end
      endcase
    end
  end

  // Pipeline register with synchronous active-low reset; reset mid-WAIT drops the op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign out_valid    = (state_q == S_VALID);
  assign alu_cmd      = out_q[WORD_W-1 -: ALU_CMD_W];
  assign mem_read     = out_q[6];
  assign mem_write    = out_q[5];
  assign branch_type  = out_q[4:3];
  assign wb_enable    = out_q[2];
  assign is_immediate = out_q[1];
  assign illegal_op   = out_q[0];

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenario tasks plus a randomized run
// checked cycle by cycle against a countdown-based behavioural model.
module tb_ctrl_decode_stage;
  localparam int OPCODE_W  = 6;
  localparam int ALU_CMD_W = 4;
  localparam int MEM_WAIT  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [OPCODE_W-1:0]  op_code = '0;
  logic                 flush = 1'b0;
  logic                 out_ready = 1'b1;
  logic                 out_valid;
  logic [ALU_CMD_W-1:0] alu_cmd;
  logic                 mem_read, mem_write, wb_enable, is_immediate, illegal_op;
  logic [1:0]           branch_type;

  int checks = 0;
  int errors = 0;

  ctrl_decode_stage #(.OPCODE_W(OPCODE_W), .ALU_CMD_W(ALU_CMD_W), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu_cmd(alu_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .branch_type(branch_type), .wb_enable(wb_enable), .is_immediate(is_immediate),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Observed control word: {alu, mem_read, mem_write, branch, wb, imm, illegal}
  wire [10:0] obs_word = {alu_cmd, mem_read, mem_write, branch_type, wb_enable, is_immediate, illegal_op};

  // Reference decode straight from the opcode table.
  function automatic logic [10:0] ref_dec(int op);
    int alu = 0, br = 0;
    bit mr = 0, mw = 0, wb = 0, imm = 0, ill = 0;
    case (op)
      0:      ;
      1:      wb = 1;
      3:      begin alu = 2;  wb = 1; end
      5, 6:   begin alu = 4;  wb = 1; end
      7:      begin alu = 6;  wb = 1; end
      8:      begin alu = 7;  wb = 1; end
      9, 10:  begin alu = 8;  wb = 1; end
      11:     begin alu = 9;  wb = 1; end
      12:     begin alu = 10; wb = 1; end
      32:     begin wb = 1; imm = 1; end
      33:     begin alu = 2; wb = 1; imm = 1; end
      36:     begin mr = 1; wb = 1; end
      37:     mw = 1;
      40:     br = 1;
      41:     br = 2;
      42:     br = 3;
      default: ill = 1;
    endcase
    return {4'(alu), mr, mw, 2'(br), wb, imm, ill};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; op_code = 6'd1; out_ready = 1'b1; flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_early got %b exp 0", in_ready); end
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (obs_word !== 11'd0) begin errors++; $display("FAIL reset_word got %h exp 000", obs_word); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int ops [4] = '{1, 3, 32, 40};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op_code = 6'(ops[i]); out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready op %0d got %b exp 1", ops[i], in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs_word !== ref_dec(ops[i]))
        begin errors++; $display("FAIL stream_out op %0d got v=%b w=%h exp v=1 w=%h", ops[i], out_valid, obs_word, ref_dec(ops[i])); end
    end
    // Literal spot checks of the table rows being streamed.
    checks++;
    if (branch_type !== 2'b01 || wb_enable !== 1'b0) begin errors++; $display("FAIL stream_bez got br=%b wb=%b exp br=01 wb=0", branch_type, wb_enable); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_mem_wait();
    in_valid = 1'b1; op_code = 6'd36; out_ready = 1'b1;
    #1;
    tick();
    op_code = 6'd1;   // offered during the wait; must not be taken
    for (int c = 1; c <= MEM_WAIT; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL mem_wait cycle %0d got v=%b rdy=%b exp v=0 rdy=0", c, out_valid, in_ready); end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b1 || mem_read !== 1'b1 || wb_enable !== 1'b1 || obs_word !== ref_dec(36))
      begin errors++; $display("FAIL mem_load_out got v=%b w=%h exp v=1 w=%h", out_valid, obs_word, ref_dec(36)); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mem_valid_ready got %b exp 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs_word !== ref_dec(1))
      begin errors++; $display("FAIL mem_followup got v=%b w=%h exp v=1 w=%h", out_valid, obs_word, ref_dec(1)); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; op_code = 6'd7; out_ready = 1'b1;
    #1;
    tick();
    out_ready = 1'b0; op_code = 6'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || alu_cmd !== 4'b0110 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold cycle %0d got v=%b alu=%b rdy=%b exp v=1 alu=0110 rdy=0", c, out_valid, alu_cmd, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs_word !== ref_dec(3))
      begin errors++; $display("FAIL bp_next got v=%b w=%h exp v=1 w=%h", out_valid, obs_word, ref_dec(3)); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; op_code = 6'd37; out_ready = 1'b1;
    #1;
    tick();
    flush = 1'b1; op_code = 6'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || obs_word !== 11'd0)
        begin errors++; $display("FAIL flush_wait cycle %0d got v=%b w=%h exp v=0 w=000", c, out_valid, obs_word); end
      tick();
    end
    // Flush of a held valid entry under backpressure.
    in_valid = 1'b1; op_code = 6'd11;
    #1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || obs_word !== 11'd0)
      begin errors++; $display("FAIL flush_valid got v=%b w=%h exp v=0 w=000", out_valid, obs_word); end
  endtask

  task automatic test_illegal();
    int ops [3] = '{2, 63, 12};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op_code = 6'(ops[i]); out_ready = 1'b1;
      #1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs_word !== ref_dec(ops[i]))
        begin errors++; $display("FAIL illegal_out op %0d got v=%b w=%h exp v=1 w=%h", ops[i], out_valid, obs_word, ref_dec(ops[i])); end
      if (i < 2) begin
        checks++;
        if (illegal_op !== 1'b1 || alu_cmd !== 4'd0)
          begin errors++; $display("FAIL illegal_flag op %0d got ill=%b alu=%b exp ill=1 alu=0000", ops[i], illegal_op, alu_cmd); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int legal [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
    bit         m_full = 0;
    int         m_wait = 0;     // cycles left before the held entry becomes visible
    logic [10:0] m_word = '0;
    bit         exp_ov, exp_ir, acc;
    logic [10:0] exp_w;
    int         op;
    for (int i = 0; i < 600; i++) begin
      exp_ov = m_full && (m_wait == 0);
      exp_w  = exp_ov ? m_word : 11'd0;
      checks++;
      if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", i, out_valid, exp_ov); end
      checks++;
      if (obs_word !== exp_w) begin errors++; $display("FAIL rnd_word cyc %0d got %h exp %h", i, obs_word, exp_w); end

      op        = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 17)] : int'($urandom_range(0, 63));
      rst_n     = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      op_code   = 6'(op);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_ir = rst_n && !flush && (!m_full || (m_wait == 0 && out_ready));
      checks++;
      if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, in_ready, exp_ir); end
      acc = in_valid && exp_ir;

      if (!rst_n || flush)          m_full = 0;
      else if (m_full && m_wait > 0) m_wait--;
      else if (m_full && out_ready)  m_full = 0;
      if (acc) begin
        m_full = 1;
        m_word = ref_dec(op);
        m_wait = (op == 36 || op == 37) ? MEM_WAIT : 0;
      end
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mem_wait();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
